// File: rtl/decoder38_pulse_pkg.sv
// Shared types and widths for the 3:8 pulse decoder and its 8:3 encoder counterpart.
// Optional feature macro: DEC_PARITY_EN (odd parity on the input code).
package decoder38_pulse_pkg;

   localparam int DEC_CODE_W   = 3;
   localparam int DEC_ONEHOT_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   // Odd parity: the parity bit together with the code must have an odd number of ones.
   function automatic logic parity_ok(input logic par, input logic [DEC_CODE_W-1:0] code);
      return ^{par, code};
   endfunction

endpackage

// File: rtl/decoder38_pulse_if.sv
// Handshake/output bundle of decoder38_pulse; master = code sender, slave = decoder.
// Optional feature macro: DEC_PARITY_EN adds in_parity and err.
interface decoder38_pulse_if;
   import decoder38_pulse_pkg::*;

   logic                    in_valid;
   logic                    in_ready;
   logic [DEC_CODE_W-1:0]   in_code;
   logic [DEC_ONEHOT_W-1:0] y;
   logic                    busy;
`ifdef DEC_PARITY_EN
   logic                    in_parity;
   logic                    err;

   modport master (output in_valid, in_code, in_parity,
                   input  in_ready, y, busy, err);
   modport slave  (input  in_valid, in_code, in_parity,
                   output in_ready, y, busy, err);
`else
   modport master (output in_valid, in_code,
                   input  in_ready, y, busy);
   modport slave  (input  in_valid, in_code,
                   output in_ready, y, busy);
`endif

endinterface

// File: rtl/decoder38_pulse_dec.sv
// Purely combinational 3->8 one-hot core used by decoder38_pulse.
module decoder38
   import decoder38_pulse_pkg::*;
(
   input  logic [DEC_CODE_W-1:0]   code,
   output logic [DEC_ONEHOT_W-1:0] onehot
);

   always_comb begin
      onehot = '0;
      case (code)
         3'd0:    onehot = 8'h01;
         3'd1:    onehot = 8'h02;
         3'd2:    onehot = 8'h04;
         3'd3:    onehot = 8'h08;
         3'd4:    onehot = 8'h10;
         3'd5:    onehot = 8'h20;
         3'd6:    onehot = 8'h40;
         3'd7:    onehot = 8'h80;
         default: onehot = '0;
      endcase
   end

endmodule

// File: rtl/decoder38_pulse.sv
// Sequential 3:8 decoder: accepts a code over valid/ready, holds the one-hot line for
// HOLD_CYCLES, then idles GAP_CYCLES. Optional macro DEC_PARITY_EN: odd-parity check + err.
module decoder38_pulse
   import decoder38_pulse_pkg::*;
#(
   parameter int HOLD_CYCLES = 4,
   parameter int GAP_CYCLES  = 1,
   parameter int CNT_W       = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   decoder38_pulse_if.slave  bus
);

   localparam int MAX_LOAD = ((HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES) - 1;

   if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
      $fatal(1, "decoder38_pulse: HOLD_CYCLES must be 1..255");
   end
   if (GAP_CYCLES < 0 || GAP_CYCLES > 255) begin : g_bad_gap
      $fatal(1, "decoder38_pulse: GAP_CYCLES must be 0..255");
   end
   if (CNT_W < 1 || CNT_W > 31 || MAX_LOAD >= (1 << CNT_W)) begin : g_bad_cnt
      $fatal(1, "decoder38_pulse: CNT_W too narrow for HOLD/GAP length");
   end

   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

   state_t                    state_p1;
   logic [CNT_W-1:0]          cnt_p1;
   logic [DEC_ONEHOT_W-1:0]   y_p1;
   logic [DEC_ONEHOT_W-1:0]   onehot_p0;
   logic                      accept_p0;
   logic                      par_ok_p0;

   // Stage p0: handshake qualification and combinational decode of the offered code
   assign accept_p0 = bus.in_valid & bus.in_ready;

   decoder38 u_core (
      .code   (bus.in_code),
      .onehot (onehot_p0)
   );

`ifdef DEC_PARITY_EN
   logic err_p1;
   assign par_ok_p0 = parity_ok(bus.in_parity, bus.in_code);
   assign bus.err   = err_p1;
`else
   assign par_ok_p0 = 1'b1;
`endif

   // Stage p1: FSM, hold/gap counter and registered one-hot output
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_p1 <= ST_IDLE;
         cnt_p1   <= '0;
         y_p1     <= '0;
`ifdef DEC_PARITY_EN
         err_p1   <= 1'b0;
`endif
      end else begin
`ifdef DEC_PARITY_EN
         err_p1 <= 1'b0;
`endif
         unique case (state_p1)
            ST_IDLE: begin
               if (accept_p0) begin
                  if (par_ok_p0) begin
                     y_p1     <= onehot_p0;
                     cnt_p1   <= HOLD_LOAD;
                     state_p1 <= ST_HOLD;
                  end
`ifdef DEC_PARITY_EN
                  else begin
                     // Bad parity: code is consumed without firing a strobe.
                     err_p1 <= 1'b1;
                  end
`endif
               end
            end
            ST_HOLD: begin
               if (cnt_p1 == '0) begin
                  y_p1     <= '0;
                  cnt_p1   <= GAP_LOAD;
                  state_p1 <= (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
               end else begin
                  cnt_p1 <= cnt_p1 - 1'b1;
               end
            end
            ST_GAP: begin
               if (cnt_p1 == '0) begin
                  state_p1 <= ST_IDLE;
               end else begin
                  cnt_p1 <= cnt_p1 - 1'b1;
               end
            end
            default: begin
               y_p1     <= '0;
               cnt_p1   <= '0;
               state_p1 <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.y        = y_p1;
   assign bus.in_ready = rst_n & (state_p1 == ST_IDLE);
   assign bus.busy     = (state_p1 != ST_IDLE);

endmodule
